// File: rtl/rv_pkg.sv
// Shared RV core widths and register-index type, reused by the register file,
// the execute units and the write-back arbiter.
package rv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 2 ** REG_AW;

   typedef logic [REG_AW-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the ALU / MUL-DIV producers, the issue stage and the write-back arbiter.
interface regfile_wb_arbiter_if
   import rv_pkg::*;
#(
   parameter int unsigned XLEN   = rv_pkg::XLEN,
   parameter int unsigned REG_AW = rv_pkg::REG_AW
);

   logic                  alu_valid;
   logic [REG_AW-1:0]     alu_rd;
   logic [XLEN-1:0]       alu_data;
   logic                  alu_ready;

   logic                  md_valid;
   logic [REG_AW-1:0]     md_rd;
   logic [XLEN-1:0]       md_data;
   logic                  md_ready;

   logic                  issue_valid;
   logic                  issue_is_md;
   logic [REG_AW-1:0]     issue_rs1;
   logic [REG_AW-1:0]     issue_rs2;
   logic [REG_AW-1:0]     issue_rd;
   logic                  issue_stall;

   logic [REG_AW-1:0]     rd;
   logic [XLEN-1:0]       rD;
   logic                  rd_wd_en;
   logic [2**REG_AW-1:0]  busy;

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output md_valid, md_rd, md_data,
      input  md_ready,
      output issue_valid, issue_is_md, issue_rs1, issue_rs2, issue_rd,
      input  issue_stall,
      input  rd, rD, rd_wd_en, busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  md_valid, md_rd, md_data,
      output md_ready,
      input  issue_valid, issue_is_md, issue_rs1, issue_rs2, issue_rd,
      output issue_stall,
      output rd, rD, rd_wd_en, busy
   );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Destination scoreboard for in-flight MUL/DIV ops and the issue-stage hazard check.
module wb_scoreboard
   import rv_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_issue_valid,
   input  logic                i_issue_is_md,
   input  reg_idx_t            i_issue_rs1,
   input  reg_idx_t            i_issue_rs2,
   input  reg_idx_t            i_issue_rd,
   input  logic                i_clr_en,
   input  reg_idx_t            i_clr_idx,
   output logic [NUM_REGS-1:0] o_busy,
   output logic                o_stall
);

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_stall;

   // busy[0] is never set, so x0 operands can never raise a hazard
   assign w_stall = i_issue_valid &&
                    (r_busy[i_issue_rs1] || r_busy[i_issue_rs2] || r_busy[i_issue_rd]);

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_issue_valid && i_issue_is_md && !w_stall && (i_issue_rd != REG_ZERO))
         w_set_mask[i_issue_rd] = 1'b1;
      if (i_clr_en)
         w_clr_mask[i_clr_idx] = 1'b1;
      // set applied after clear so a same-index collision leaves the bit set
      w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign o_busy  = r_busy;
   assign o_stall = w_stall;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: fixed-priority (MUL/DIV first) sharing of the register-file
// write port, registered with one cycle of latency, plus MUL/DIV hazard scoreboard.
module regfile_wb_arbiter
   import rv_pkg::*;
#(
   parameter int unsigned XLEN   = rv_pkg::XLEN,
   parameter int unsigned REG_AW = rv_pkg::REG_AW
)(
   input  logic                  clk,
   input  logic                  rst,
   regfile_wb_arbiter_if.slave   bus
);

   logic                  w_md_ready;
   logic                  w_alu_ready;
   logic [REG_AW-1:0]     r_rd;
   logic [XLEN-1:0]       r_rD;
   logic                  r_rd_wd_en;
   logic [2**REG_AW-1:0]  w_busy;
   logic                  w_issue_stall;

   assign w_md_ready  = bus.md_valid;
   assign w_alu_ready = bus.alu_valid && !bus.md_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd       <= '0;
         r_rD       <= '0;
         r_rd_wd_en <= 1'b0;
      end else if (w_md_ready) begin
         r_rd       <= bus.md_rd;
         r_rD       <= bus.md_data;
         r_rd_wd_en <= (bus.md_rd != REG_ZERO);
      end else if (w_alu_ready) begin
         r_rd       <= bus.alu_rd;
         r_rD       <= bus.alu_data;
         r_rd_wd_en <= (bus.alu_rd != REG_ZERO);
      end else begin
         r_rd_wd_en <= 1'b0;
      end
   end

   wb_scoreboard u_scoreboard (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_issue_valid (bus.issue_valid),
      .i_issue_is_md (bus.issue_is_md),
      .i_issue_rs1   (bus.issue_rs1),
      .i_issue_rs2   (bus.issue_rs2),
      .i_issue_rd    (bus.issue_rd),
      .i_clr_en      (w_md_ready),
      .i_clr_idx     (bus.md_rd),
      .o_busy        (w_busy),
      .o_stall       (w_issue_stall)
   );

   // WAW stalling at issue guarantees an ALU result never targets a busy register
   a_alu_not_busy: assert property (@(posedge clk) disable iff (rst)
      w_alu_ready |-> !w_busy[bus.alu_rd]);

   assign bus.md_ready    = w_md_ready;
   assign bus.alu_ready   = w_alu_ready;
   assign bus.rd          = r_rd;
   assign bus.rD          = r_rD;
   assign bus.rd_wd_en    = r_rd_wd_en;
   assign bus.busy        = w_busy;
   assign bus.issue_stall = w_issue_stall;

endmodule
